// File: rtl/od_bridge_ctrl_if.sv
// Sideband pad bundle between the bridge controller and the pad/bench side.
// The slave side is the controller: it samples the pad levels and drives the low-enables.
interface od_bridge_ctrl_if;
  logic       iEn;
  logic       iA;
  logic       iB;
  logic       iFaultClr;
  logic       oA_drvLow;
  logic       oB_drvLow;
  logic [1:0] oOwner;
  logic       oFault;

  modport slave (
    input  iEn, iA, iB, iFaultClr,
    output oA_drvLow, oB_drvLow, oOwner, oFault
  );

  modport master (
    output iEn, iA, iB, iFaultClr,
    input  oA_drvLow, oB_drvLow, oOwner, oFault
  );
endinterface

// File: rtl/od_bridge_ctrl.sv
// Open-drain bypass direction control: pad edge to drive change is 2 + FILT_CYC + 1 cycles, no backpressure.
// OD_BRIDGE_TIMEOUT_EN adds the stuck-low timeout and latched FAULT state; without it ownership never times out.
module od_bridge_ctrl #(
  parameter int FILT_CYC    = 2,
  parameter int RELEASE_CYC = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            iClk,
  input  logic            iRst,
  od_bridge_ctrl_if.slave bus
);
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RELEASE_CYC - 1);

`ifdef OD_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, A_OWNS, B_OWNS, HOLDOFF, FAULT} state_t;
  logic [15:0] toCnt;
`else
  typedef enum logic [1:0] {IDLE, A_OWNS, B_OWNS, HOLDOFF} state_t;
  logic unusedIn;
  assign unusedIn = ^{bus.iFaultClr, 16'(TIMEOUT_CYC)};
`endif

  state_t     stateQ, stateD;
  logic       aMeta, aSync, bMeta, bSync;
  logic       fA, fB;
  logic [3:0] filtCntA, filtCntB;
  logic [7:0] holdCnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      aMeta <= 1'b1;
      aSync <= 1'b1;
      bMeta <= 1'b1;
      bSync <= 1'b1;
    end else begin
      aMeta <= bus.iA;
      aSync <= aMeta;
      bMeta <= bus.iB;
      bSync <= bMeta;
    end
  end

  // Filtered level flips only after FILT_CYC consecutive disagreeing samples.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fA       <= 1'b1;
      filtCntA <= '0;
    end else if (!bus.iEn || aSync == fA) begin
      filtCntA <= '0;
    end else if (filtCntA == FILT_LAST) begin
      fA       <= aSync;
      filtCntA <= '0;
    end else begin
      filtCntA <= filtCntA + 4'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      fB       <= 1'b1;
      filtCntB <= '0;
    end else if (!bus.iEn || bSync == fB) begin
      filtCntB <= '0;
    end else if (filtCntB == FILT_LAST) begin
      fB       <= bSync;
      filtCntB <= '0;
    end else begin
      filtCntB <= filtCntB + 4'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ  <= IDLE;
      holdCnt <= '0;
`ifdef OD_BRIDGE_TIMEOUT_EN
      toCnt   <= '0;
`endif
    end else begin
      stateQ  <= stateD;
      holdCnt <= (stateQ == HOLDOFF && stateD == HOLDOFF) ? holdCnt + 8'd1 : '0;
`ifdef OD_BRIDGE_TIMEOUT_EN
      if ((stateQ == A_OWNS || stateQ == B_OWNS) && stateD == stateQ)
        toCnt <= (toCnt == 16'hFFFF) ? toCnt : toCnt + 16'd1;
      else
        toCnt <= '0;
`endif
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (!fA && fB)
          stateD = A_OWNS;
        else if (fA && !fB)
          stateD = B_OWNS;
      end
      A_OWNS: begin
        if (fA)
          stateD = HOLDOFF;
`ifdef OD_BRIDGE_TIMEOUT_EN
        else if (toCnt == TO_LAST)
          stateD = FAULT;
`endif
      end
      B_OWNS: begin
        if (fB)
          stateD = HOLDOFF;
`ifdef OD_BRIDGE_TIMEOUT_EN
        else if (toCnt == TO_LAST)
          stateD = FAULT;
`endif
      end
      HOLDOFF: begin
        if (holdCnt == HOLD_LAST)
          stateD = IDLE;
      end
`ifdef OD_BRIDGE_TIMEOUT_EN
      FAULT: begin
        if (bus.iFaultClr && fA && fB)
          stateD = IDLE;
      end
`endif
      default: stateD = IDLE;
    endcase
    // Disable drops ownership but must not wipe a latched fault.
`ifdef OD_BRIDGE_TIMEOUT_EN
    if (!bus.iEn && stateQ != FAULT)
      stateD = IDLE;
`else
    if (!bus.iEn)
      stateD = IDLE;
`endif
  end

  assign bus.oA_drvLow = (stateQ == B_OWNS);
  assign bus.oB_drvLow = (stateQ == A_OWNS);
`ifdef OD_BRIDGE_TIMEOUT_EN
  assign bus.oFault    = (stateQ == FAULT);
`else
  assign bus.oFault    = 1'b0;
`endif

  always_comb begin
    bus.oOwner = 2'b00;
    case (stateQ)
      A_OWNS:  bus.oOwner = 2'b01;
      B_OWNS:  bus.oOwner = 2'b10;
      HOLDOFF: bus.oOwner = 2'b11;
      default: bus.oOwner = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_od_bridge_ctrl.sv
// Bench for od_bridge_ctrl: pads are wired-AND of bench pull-downs and the DUT drives,
// so the drive echo appears on the pad exactly as on a real open-drain wire.
module tb_od_bridge_ctrl;
  localparam int FILT    = 2;
  localparam int RELEASE = 4;
  localparam int TO_CYC  = 16;
`ifdef OD_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aExt = 1'b1;
  logic bExt = 1'b1;
  int   checks = 0;
  int   errors = 0;

  od_bridge_ctrl_if bus();
  assign bus.iA = aExt & ~bus.oA_drvLow;
  assign bus.iB = bExt & ~bus.oB_drvLow;

  od_bridge_ctrl #(.FILT_CYC(FILT), .RELEASE_CYC(RELEASE), .TIMEOUT_CYC(TO_CYC)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 A owns, 2 B owns, 3 hold-off, 4 fault; dwell measured in edges.
  int mMode = 0, mEnter = 0, mCyc = 0;
  bit mFa = 1, mFb = 1, mMetaA = 1, mSyncA = 1, mMetaB = 1, mSyncB = 1;
  bit qA[$];
  bit qB[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit a, input bit b, input bit en, input bit clr, input bit r);
    int nMode;
    mCyc++;
    if (r) begin
      mMode = 0; mEnter = mCyc;
      mFa = 1; mFb = 1; mMetaA = 1; mSyncA = 1; mMetaB = 1; mSyncB = 1;
      qA.delete(); qB.delete();
      return;
    end
    nMode = mMode;
    case (mMode)
      0: if (!mFa && mFb) nMode = 1; else if (mFa && !mFb) nMode = 2;
      1: if (mFa) nMode = 3; else if (TO_EN && (mCyc - mEnter) == TO_CYC) nMode = 4;
      2: if (mFb) nMode = 3; else if (TO_EN && (mCyc - mEnter) == TO_CYC) nMode = 4;
      3: if ((mCyc - mEnter) == RELEASE) nMode = 0;
      4: if (clr && mFa && mFb) nMode = 0;
      default: nMode = 0;
    endcase
    if (!en && mMode != 4) nMode = 0;
    if (nMode != mMode) mEnter = mCyc;
    mMode = nMode;
    if (!en || mSyncA == mFa) qA.delete();
    else begin
      qA.push_back(mSyncA);
      if (qA.size() == FILT) begin mFa = mSyncA; qA.delete(); end
    end
    if (!en || mSyncB == mFb) qB.delete();
    else begin
      qB.push_back(mSyncB);
      if (qB.size() == FILT) begin mFb = mSyncB; qB.delete(); end
    end
    mSyncA = mMetaA; mMetaA = a;
    mSyncB = mMetaB; mMetaB = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.iEn = 1'b1; bus.iFaultClr = 1'b0; aExt = 1'b1; bExt = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.oA_drvLow, bus.oB_drvLow, bus.oOwner, bus.oFault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000", {bus.oA_drvLow, bus.oB_drvLow, bus.oOwner, bus.oFault});
    end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_glitch();
    aExt = 1'b0;
    tick();
    aExt = 1'b1;
    for (int k = 2; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.oB_drvLow !== 1'b0 || bus.oOwner !== 2'b00) begin
        errors++;
        $display("FAIL glitch k=%0d got drvB=%b owner=%b expected 0/00", k, bus.oB_drvLow, bus.oOwner);
      end
    end
  endtask

  task automatic test_a_owns();
    logic       eDrv;
    logic [1:0] eOwn;
    aExt = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      eDrv = (k >= 5 && k <= 24);
      eOwn = (k < 5) ? 2'b00 : (k <= 24) ? 2'b01 : (k <= 28) ? 2'b11 : 2'b00;
      checks++;
      if (bus.oB_drvLow !== eDrv || bus.oOwner !== eOwn || bus.oA_drvLow !== 1'b0) begin
        errors++;
        $display("FAIL a_owns k=%0d got drvA=%b drvB=%b owner=%b expected 0/%b/%b",
                 k, bus.oA_drvLow, bus.oB_drvLow, bus.oOwner, eDrv, eOwn);
      end
      if (k == 20) aExt = 1'b1;
    end
  endtask

  task automatic test_echo();
    bit sawA = 0;
    bExt = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.oOwner == 2'b01 || bus.oB_drvLow) sawA = 1;
      if (k == 30) bExt = 1'b1;
      if (k == 15) begin
        checks++;
        if (bus.oOwner !== 2'b10 || bus.oA_drvLow !== 1'b1) begin
          errors++;
          $display("FAIL echo_b_owns got owner=%b drvA=%b expected 10/1", bus.oOwner, bus.oA_drvLow);
        end
      end
    end
    checks++;
    if (sawA || bus.oOwner !== 2'b00) begin
      errors++;
      $display("FAIL echo_immunity got sawA=%0d owner=%b expected 0/00", sawA, bus.oOwner);
    end
  endtask

  task automatic test_simultaneous();
    aExt = 1'b0; bExt = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 15) begin aExt = 1'b1; bExt = 1'b1; end
      checks++;
      if (bus.oA_drvLow !== 1'b0 || bus.oB_drvLow !== 1'b0 || bus.oOwner !== 2'b00) begin
        errors++;
        $display("FAIL simultaneous k=%0d got drvA=%b drvB=%b owner=%b expected 0/0/00",
                 k, bus.oA_drvLow, bus.oB_drvLow, bus.oOwner);
      end
    end
  endtask

`ifdef OD_BRIDGE_TIMEOUT_EN
  task automatic test_stuck_low();
    logic       eDrv, eFlt;
    logic [1:0] eOwn;
    aExt = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      eDrv = (k >= 5 && k <= 20);
      eFlt = (k >= 21);
      eOwn = eDrv ? 2'b01 : 2'b00;
      checks++;
      if (bus.oB_drvLow !== eDrv || bus.oFault !== eFlt || bus.oOwner !== eOwn) begin
        errors++;
        $display("FAIL stuck k=%0d got drvB=%b fault=%b owner=%b expected %b/%b/%b",
                 k, bus.oB_drvLow, bus.oFault, bus.oOwner, eDrv, eFlt, eOwn);
      end
    end
    bus.iFaultClr = 1'b1; tick(); bus.iFaultClr = 1'b0; tick();
    checks++;
    if (bus.oFault !== 1'b1 || bus.oOwner !== 2'b00) begin
      errors++;
      $display("FAIL stuck_clr_low got fault=%b owner=%b expected 1/00", bus.oFault, bus.oOwner);
    end
    aExt = 1'b1;
    repeat (6) tick();
    checks++;
    if (bus.oFault !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold got fault=%b expected 1", bus.oFault);
    end
    bus.iFaultClr = 1'b1; tick(); bus.iFaultClr = 1'b0;
    checks++;
    if (bus.oFault !== 1'b0 || bus.oOwner !== 2'b00) begin
      errors++;
      $display("FAIL stuck_clear got fault=%b owner=%b expected 0/00", bus.oFault, bus.oOwner);
    end
    repeat (4) tick();
  endtask
`else
  task automatic test_no_timeout();
    aExt = 1'b0;
    repeat (40) tick();
    bus.iFaultClr = 1'b1; tick(); bus.iFaultClr = 1'b0;
    checks++;
    if (bus.oOwner !== 2'b01 || bus.oB_drvLow !== 1'b1 || bus.oFault !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout got owner=%b drvB=%b fault=%b expected 01/1/0", bus.oOwner, bus.oB_drvLow, bus.oFault);
    end
    aExt = 1'b1;
    repeat (14) tick();
    checks++;
    if (bus.oOwner !== 2'b00) begin
      errors++;
      $display("FAIL no_timeout_release got owner=%b expected 00", bus.oOwner);
    end
  endtask
`endif

  task automatic test_drop(input bit useRst);
    bExt = 1'b0;
    repeat (8) tick();
    checks++;
    if (bus.oOwner !== 2'b10 || bus.oA_drvLow !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre rst=%0d got owner=%b drvA=%b expected 10/1", useRst, bus.oOwner, bus.oA_drvLow);
    end
    if (useRst) rst = 1'b1; else bus.iEn = 1'b0;
    tick();
    rst = 1'b0; bus.iEn = 1'b1;
    checks++;
    if (bus.oA_drvLow !== 1'b0 || bus.oOwner !== 2'b00 || bus.oFault !== 1'b0) begin
      errors++;
      $display("FAIL drop rst=%0d got drvA=%b owner=%b fault=%b expected 0/00/0",
               useRst, bus.oA_drvLow, bus.oOwner, bus.oFault);
    end
    bExt = 1'b1;
    repeat (25) tick();
    checks++;
    if (bus.oOwner !== 2'b00) begin
      errors++;
      $display("FAIL drop_settle rst=%0d got owner=%b expected 00", useRst, bus.oOwner);
    end
  endtask

  task automatic test_random();
    bit r, en, clr, a, b;
    for (int i = 0; i < 4000; i++) begin
      r   = (i == 0) || ($urandom_range(399) == 0);
      en  = ($urandom_range(99) != 0);
      clr = ($urandom_range(19) == 0);
      if ($urandom_range(11) == 0) aExt = ~aExt;
      if ($urandom_range(11) == 0) bExt = ~bExt;
      rst = r; bus.iEn = en; bus.iFaultClr = clr;
      a = aExt & (mMode != 2);
      b = bExt & (mMode != 1);
      @(posedge clk);
      model_step(a, b, en, clr, r);
      #1;
      checks++;
      if (bus.oA_drvLow !== (mMode == 2) || bus.oB_drvLow !== (mMode == 1) ||
          bus.oOwner !== ((mMode >= 1 && mMode <= 3) ? 2'(mMode) : 2'b00) ||
          bus.oFault !== (mMode == 4)) begin
        errors++;
        $display("FAIL random i=%0d got drvA=%b drvB=%b owner=%b fault=%b expected mode %0d",
                 i, bus.oA_drvLow, bus.oB_drvLow, bus.oOwner, bus.oFault, mMode);
      end
    end
    rst = 1'b0; bus.iEn = 1'b1; bus.iFaultClr = 1'b0;
  endtask

  initial begin
    bus.iEn = 1'b1;
    bus.iFaultClr = 1'b0;
    test_reset();
    test_glitch();
    test_a_owns();
    test_echo();
    test_simultaneous();
`ifdef OD_BRIDGE_TIMEOUT_EN
    test_stuck_low();
`else
    test_no_timeout();
`endif
    test_drop(1'b0);
    test_drop(1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/od_bridge_ctrl.md
Name: od_bridge_ctrl

Overview:
- Direction controller for one open-drain bypass channel between two sideband pads (SMBus/I2C or wired-OR reset/alert pair).
- Synchronizes and deglitches both pad inputs and decides which side owns the wire.
- Drives the opposite side low while the owner is low, and enforces a release hold-off so the echoed low is never mistaken for a new request.
- Detects stuck-low buses and latches a fault for the PFR logic.

Parameters:
- FILT_CYC, 2: consecutive identical synchronized samples required before the filtered level changes (1..15).
- RELEASE_CYC, 4: hold-off cycles after an owner releases, during which both sides are ignored (1..255).
- TIMEOUT_CYC, 1024: cycles an owner may hold low before fault (2..65535).

Ports:
- iClk, input, 1: system clock.
- iRst, input, 1: synchronous reset, active-high.
- iEn, input, 1: bridge enable. 0 forces IDLE and no drive.
- iA, input, 1: pad A level (asynchronous).
- iB, input, 1: pad B level (asynchronous).
- iFaultClr, input, 1: single-cycle fault clear request.
- oA_drvLow, output, 1: 1 = drive pad A low; 0 = release to high-Z.
- oB_drvLow, output, 1: 1 = drive pad B low; 0 = release to high-Z.
- oOwner, output, 2: 00 none, 01 A owns, 10 B owns, 11 hold-off.
- oFault, output, 1: stuck-low fault latched.

Behaviour:
- Interface: one clock iClk. Reset iRst is synchronous and active-high, sampled only on the iClk rising edge.
- Reset values: every output 0; state IDLE; sync flops 1; filtered levels fA and fB 1; all counters 0.
- Input path:
  - Two-flop synchronizer per pad.
  - Per-pad filter counter: fX takes the synchronized value after FILT_CYC consecutive cycles that differ from fX; any agreeing sample clears the counter.
- State machine (registered outputs decoded from the state register):
  - IDLE: no drive, oOwner=00.
    - fA=0 and fB=1 → A_OWNS.
    - fA=1 and fB=0 → B_OWNS.
    - Both 0 in the same cycle → stay IDLE; no drive, no ownership.
  - A_OWNS: oB_drvLow=1, oOwner=01. B is ignored.
    - fA=1 → HOLDOFF.
    - Timeout counter reaches TIMEOUT_CYC → FAULT.
  - B_OWNS: mirror of A_OWNS with oA_drvLow=1, oOwner=10.
  - HOLDOFF: no drive, oOwner=11.
    - Counts RELEASE_CYC cycles, then → IDLE.
    - Pads are not evaluated during hold-off.
    - If a pad is still low on return to IDLE, normal IDLE rules apply.
  - FAULT: no drive, oFault=1, oOwner=00.
    - Leaves for IDLE only when iFaultClr=1 and fA=1 and fB=1 in the same cycle.
    - A clear with either pad low is ignored and oFault stays 1.
- Timeout counter:
  - 16 bits; cleared on every owner-state entry; saturating.
  - Increments every cycle in A_OWNS or B_OWNS.
- Latency: pad edge to drive assertion is 2 + FILT_CYC + 1 cycles (5 with defaults). Release latency is the same.
- iEn=0:
  - Next cycle the state is IDLE, drives are 0, and counters are cleared.
  - oFault holds its value; only iFaultClr or reset clears it.
  - In FAULT, iEn=0 leaves the state in FAULT.
- Reset mid-ownership: drive is released the cycle after iRst is sampled high.
- The block never asserts oA_drvLow and oB_drvLow together in any state.

Optional Feature:
- Macro: OD_BRIDGE_TIMEOUT_EN.
- Defined: timeout counter, FAULT state and oFault behave as above.
- Undefined:
  - No timeout counter and no FAULT state.
  - oFault is tied to 0 and iFaultClr is ignored.
  - Ownership lasts indefinitely while the owner holds low.

Test Plan:
- Glitch reject: A low for 1 cycle, defaults → oB_drvLow stays 0, state stays IDLE.
- A-owns transfer: A low for 20 cycles → oB_drvLow=1 from cycle 5 to cycle 25; then oOwner=11 for 4 cycles; then 00; oA_drvLow=0 throughout.
- Echo immunity: B tied externally to follow oB_drvLow → after A releases there is no B_OWNS entry, and the state returns to IDLE.
- Simultaneous: A and B fall in the same cycle → both drives stay 0 and oOwner=00 for the whole low period.
- Stuck low (macro defined, TIMEOUT_CYC=16): A held low → oFault=1 and drives released 16 cycles after A_OWNS entry. iFaultClr while A is low → oFault stays 1. A released, then iFaultClr → IDLE and oFault=0.
- iEn drop during B_OWNS → oA_drvLow=0 next cycle, oOwner=00. A synchronous iRst pulse gives the same response.
